// File: rtl/m5_mem_pkg.sv
// Shared types for the sordM5 SDRAM arbiter: requester ids, FSM states and
// the layout of one buffered download byte.
package m5_mem_pkg;

  typedef enum logic [1:0] {
    OWN_DL   = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_TAPE = 2'd2
  } owner_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_ACK = 2'd2
  } arb_state_e;

  localparam logic [7:0] IOCTL_IDX_ROM = 8'd1;
  localparam logic [7:0] IOCTL_IDX_CAS = 8'd2;

  localparam int DL_W = 33;

  typedef struct packed {
    logic [24:0] addr;
    logic [7:0]  data;
  } dl_entry_t;

endpackage

// File: rtl/m5_dl_fifo.sv
// Small FIFO holding download bytes with their SDRAM addresses.
// The head entry is read straight from registered storage; a push is never visible in the same cycle.
module m5_dl_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count == (AW+1)'(DEPTH));
  assign empty_o = (count == '0);
  assign dout_o  = mem[rd_ptr];

  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= din_i;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/m5_sdram_arbiter.sv
// Shares the byte-wide SDRAM controller port between the ioctl download stream,
// the Z80 memory bus and the tape reader; also tracks the length of the last CAS image.
module m5_sdram_arbiter
  import m5_mem_pkg::*;
#(
  parameter logic [24:0] ROM_BASE    = 25'h000000,
  parameter logic [24:0] CAS_BASE    = 25'h100000,
  parameter int          FIFO_DEPTH  = 4,
  parameter int          TAPE_STARVE = 8,
  parameter int          ACK_TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        ioctl_download_i,
  input  logic [7:0]  ioctl_index_i,
  input  logic        ioctl_wr_i,
  input  logic [24:0] ioctl_addr_i,
  input  logic [7:0]  ioctl_dout_i,
  input  logic        cpu_req_i,
  input  logic        cpu_we_i,
  input  logic [24:0] cpu_addr_i,
  input  logic [7:0]  cpu_din_i,
  output logic [7:0]  cpu_dout_o,
  output logic        cpu_ack_o,
  input  logic        tape_req_i,
  input  logic [23:0] tape_addr_i,
  output logic [7:0]  tape_dout_o,
  output logic        tape_ack_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [24:0] mem_addr_o,
  output logic [7:0]  mem_din_o,
  input  logic [7:0]  mem_dout_i,
  input  logic        mem_ack_i,
  output logic [23:0] cas_len_o,
  output logic        cas_valid_o,
  output logic        err_o,
  output logic [1:0]  state_o
);

  // Handshake: cpu/tape raise req as a level and hold it until their one-cycle ack;
  // mem_req_o is held with stable mem_* until the one-cycle mem_ack_i.

  arb_state_e  state;
  owner_e      owner;
  logic [15:0] tmo_cnt;
  logic [7:0]  starve_cnt;

  dl_entry_t   fifo_din;
  dl_entry_t   fifo_dout;
  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_pop;
  logic        dl_push;
  logic        fifo_overflow;

  logic        is_rom;
  logic        is_cas;
  logic        grant_valid;
  owner_e      grant_owner;
  logic        grant_we;
  logic [24:0] grant_addr;
  logic [7:0]  grant_din;
  logic        force_tape;
  logic        hold;
  logic        tmo_hit;

  logic        download_q;
  logic        cas_hit;
  logic [23:0] cas_end;
  logic [23:0] cas_max;

  assign state_o = state;

  assign is_rom        = (ioctl_index_i == IOCTL_IDX_ROM);
  assign is_cas        = (ioctl_index_i == IOCTL_IDX_CAS);
  assign dl_push       = ioctl_wr_i & ioctl_download_i & (is_rom | is_cas);
  assign fifo_din.addr = (is_cas ? CAS_BASE : ROM_BASE) + ioctl_addr_i;
  assign fifo_din.data = ioctl_dout_i;
  assign fifo_overflow = dl_push & fifo_full & ~fifo_pop;

  m5_dl_fifo #(
    .WIDTH(DL_W),
    .DEPTH(FIFO_DEPTH)
  ) u_dl_fifo (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .push_i   (dl_push),
    .din_i    (fifo_din),
    .pop_i    (fifo_pop),
    .dout_o   (fifo_dout),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty)
  );

  // While an ack is pulsing the requester may still show req high; skip one decision so it is not served twice.
  assign hold       = cpu_ack_o | tape_ack_o;
  assign force_tape = tape_req_i & (starve_cnt == 8'(TAPE_STARVE));
  assign tmo_hit    = (state == WAIT_ACK) & ~mem_ack_i & (tmo_cnt == 16'(ACK_TIMEOUT - 1));

  always_comb begin
    grant_valid = 1'b0;
    grant_owner = OWN_DL;
    if (state == IDLE && !hold) begin
      if (force_tape) begin
        grant_valid = 1'b1;
        grant_owner = OWN_TAPE;
      end else if (!fifo_empty) begin
        grant_valid = 1'b1;
        grant_owner = OWN_DL;
      end else if (cpu_req_i) begin
        grant_valid = 1'b1;
        grant_owner = OWN_CPU;
      end else if (tape_req_i) begin
        grant_valid = 1'b1;
        grant_owner = OWN_TAPE;
      end
    end
  end

  always_comb begin
    grant_we   = 1'b0;
    grant_addr = CAS_BASE + {1'b0, tape_addr_i};
    grant_din  = 8'h00;
    case (grant_owner)
      OWN_DL: begin
        grant_we   = 1'b1;
        grant_addr = fifo_dout.addr;
        grant_din  = fifo_dout.data;
      end
      OWN_CPU: begin
        grant_we   = cpu_we_i;
        grant_addr = cpu_addr_i;
        grant_din  = cpu_din_i;
      end
      default: ;
    endcase
  end

  assign fifo_pop = grant_valid & (grant_owner == OWN_DL);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state       <= IDLE;
      owner       <= OWN_DL;
      tmo_cnt     <= '0;
      starve_cnt  <= '0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_din_o   <= '0;
      cpu_ack_o   <= 1'b0;
      cpu_dout_o  <= '0;
      tape_ack_o  <= 1'b0;
      tape_dout_o <= '0;
      err_o       <= 1'b0;
    end else begin
      cpu_ack_o  <= 1'b0;
      tape_ack_o <= 1'b0;
      err_o      <= err_o | fifo_overflow | tmo_hit;

      if (!tape_req_i || (grant_valid && grant_owner == OWN_TAPE))
        starve_cnt <= '0;
      else if (grant_valid && grant_owner == OWN_CPU && !force_tape)
        starve_cnt <= starve_cnt + 8'd1;

      case (state)
        IDLE: begin
          if (grant_valid) begin
            owner      <= grant_owner;
            mem_we_o   <= grant_we;
            mem_addr_o <= grant_addr;
            mem_din_o  <= grant_din;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          mem_req_o <= 1'b1;
          tmo_cnt   <= '0;
          state     <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (mem_ack_i) begin
            mem_req_o <= 1'b0;
            state     <= IDLE;
            if (owner == OWN_CPU) begin
              cpu_ack_o  <= 1'b1;
              cpu_dout_o <= mem_dout_i;
            end
            if (owner == OWN_TAPE) begin
              tape_ack_o  <= 1'b1;
              tape_dout_o <= mem_dout_i;
            end
          end else if (tmo_hit) begin
            // Abandon silently; the owner still holds req and is served again.
            mem_req_o <= 1'b0;
            state     <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign cas_hit = ioctl_wr_i & ioctl_download_i & is_cas;
  assign cas_end = ioctl_addr_i[23:0] + 24'd1;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      download_q  <= 1'b0;
      cas_max     <= '0;
      cas_len_o   <= '0;
      cas_valid_o <= 1'b0;
    end else begin
      download_q <= ioctl_download_i;
      if (ioctl_download_i && !download_q && is_cas) begin
        cas_valid_o <= 1'b0;
        cas_max     <= cas_hit ? cas_end : 24'd0;
      end else if (cas_hit && cas_end > cas_max) begin
        cas_max <= cas_end;
      end
      if (!ioctl_download_i && download_q && is_cas) begin
        cas_len_o   <= cas_max;
        cas_valid_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_m5_sdram_arbiter.sv
// Directed bench for m5_sdram_arbiter: a negedge SDRAM responder logs every
// completed access, and a scoreboard compares that log against hand-built expectations.
module tb_m5_sdram_arbiter;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic        ioctl_download_i;
  logic [7:0]  ioctl_index_i;
  logic        ioctl_wr_i;
  logic [24:0] ioctl_addr_i;
  logic [7:0]  ioctl_dout_i;
  logic        cpu_req_i;
  logic        cpu_we_i;
  logic [24:0] cpu_addr_i;
  logic [7:0]  cpu_din_i;
  logic [7:0]  cpu_dout_o;
  logic        cpu_ack_o;
  logic        tape_req_i;
  logic [23:0] tape_addr_i;
  logic [7:0]  tape_dout_o;
  logic        tape_ack_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [24:0] mem_addr_o;
  logic [7:0]  mem_din_o;
  logic [7:0]  mem_dout_i;
  logic        mem_ack_i;
  logic [23:0] cas_len_o;
  logic        cas_valid_o;
  logic        err_o;
  logic [1:0]  state_o;

  always #5 clk_i = ~clk_i;

  m5_sdram_arbiter dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .ioctl_download_i(ioctl_download_i), .ioctl_index_i(ioctl_index_i),
    .ioctl_wr_i(ioctl_wr_i), .ioctl_addr_i(ioctl_addr_i), .ioctl_dout_i(ioctl_dout_i),
    .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i), .cpu_din_i(cpu_din_i),
    .cpu_dout_o(cpu_dout_o), .cpu_ack_o(cpu_ack_o),
    .tape_req_i(tape_req_i), .tape_addr_i(tape_addr_i), .tape_dout_o(tape_dout_o), .tape_ack_o(tape_ack_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_din_o(mem_din_o),
    .mem_dout_i(mem_dout_i), .mem_ack_i(mem_ack_i),
    .cas_len_o(cas_len_o), .cas_valid_o(cas_valid_o), .err_o(err_o), .state_o(state_o)
  );

  int checks = 0;
  int errors = 0;

  // Scoreboard entries: {we, addr[24:0], din[7:0]}
  logic [33:0] exp_q[$];
  logic [33:0] got_q[$];

  int         ack_delay = 2;
  bit         ack_en    = 1'b1;
  bit         log_en    = 1'b1;
  logic [7:0] rd_data   = 8'h3C;
  int         resp_cnt  = 0;

  task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // SDRAM controller model: acks ack_delay negedges after seeing mem_req_o.
  always @(negedge clk_i) begin
    if (mem_ack_i) begin
      mem_ack_i = 1'b0;
      resp_cnt  = 0;
    end else if (mem_req_o && ack_en) begin
      resp_cnt++;
      if (resp_cnt >= ack_delay) begin
        mem_ack_i  = 1'b1;
        mem_dout_i = rd_data;
        if (log_en) got_q.push_back({mem_we_o, mem_addr_o, mem_din_o});
      end
    end else begin
      resp_cnt = 0;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic do_reset();
    reset_n_i        = 1'b0;
    ioctl_download_i = 1'b0;
    ioctl_index_i    = 8'd0;
    ioctl_wr_i       = 1'b0;
    ioctl_addr_i     = '0;
    ioctl_dout_i     = '0;
    cpu_req_i        = 1'b0;
    cpu_we_i         = 1'b0;
    cpu_addr_i       = '0;
    cpu_din_i        = '0;
    tape_req_i       = 1'b0;
    tape_addr_i      = '0;
    mem_dout_i       = '0;
    mem_ack_i        = 1'b0;
    ack_en           = 1'b1;
    log_en           = 1'b1;
    repeat (3) @(negedge clk_i);
    reset_n_i = 1'b1;
    @(negedge clk_i);
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic dl_byte(input logic [24:0] addr, input logic [7:0] data);
    ioctl_wr_i   = 1'b1;
    ioctl_addr_i = addr;
    ioctl_dout_i = data;
    @(negedge clk_i);
    ioctl_wr_i   = 1'b0;
  endtask

  task automatic wait_log(input string tag, input int n, input int budget);
    int k = 0;
    while (got_q.size() < n && k < budget) begin
      @(negedge clk_i);
      k++;
    end
    check(tag, 40'(got_q.size() >= n), 40'd1);
  endtask

  task automatic compare_q(input string tag);
    check({tag, "_count"}, 40'(got_q.size()), 40'(exp_q.size()));
    while (exp_q.size() > 0 && got_q.size() > 0)
      check(tag, 40'(got_q.pop_front()), 40'(exp_q.pop_front()));
    exp_q.delete();
    got_q.delete();
  endtask

  initial begin
    bit seen;
    bit tape_seen;
    int n;

    // Reset state
    do_reset();
    check("rst_mem_req", 40'(mem_req_o), 40'd0);
    check("rst_acks", 40'({cpu_ack_o, tape_ack_o}), 40'd0);
    check("rst_err", 40'(err_o), 40'd0);
    check("rst_cas", 40'({cas_valid_o, cas_len_o}), 40'd0);
    check("rst_state", 40'(state_o), 40'd0);

    // ROM download, three spaced bytes
    ack_delay = 2;
    ioctl_download_i = 1'b1;
    ioctl_index_i    = 8'd1;
    dl_byte(25'd0, 8'h11); repeat (6) @(negedge clk_i);
    dl_byte(25'd1, 8'h22); repeat (6) @(negedge clk_i);
    dl_byte(25'd2, 8'h33);
    exp_q.push_back({1'b1, 25'h000000, 8'h11});
    exp_q.push_back({1'b1, 25'h000001, 8'h22});
    exp_q.push_back({1'b1, 25'h000002, 8'h33});
    wait_log("rom_wait", 3, 100);
    compare_q("rom_wr");
    check("rom_err", 40'(err_o), 40'd0);
    ioctl_download_i = 1'b0;

    // Unmapped index produces no SDRAM traffic
    @(negedge clk_i);
    ioctl_download_i = 1'b1;
    ioctl_index_i    = 8'd3;
    dl_byte(25'd7, 8'h44);
    dl_byte(25'd8, 8'h55);
    repeat (20) @(negedge clk_i);
    check("idx3_dropped", 40'(got_q.size()), 40'd0);
    ioctl_download_i = 1'b0;

    // Overflow: CPU write stalls the port while six bytes stream in
    do_reset();
    ack_delay  = 10;
    cpu_we_i   = 1'b1;
    cpu_addr_i = 25'h0000040;
    cpu_din_i  = 8'h77;
    cpu_req_i  = 1'b1;
    n = 0;
    while (!mem_req_o && n < 20) begin @(negedge clk_i); n++; end
    ioctl_download_i = 1'b1;
    ioctl_index_i    = 8'd1;
    for (int i = 0; i < 6; i++) dl_byte(25'h10 + 25'(i), 8'hC0 + 8'(i));
    check("ovf_err", 40'(err_o), 40'd1);
    seen = 1'b0;
    n = 0;
    while (!seen && n < 50) begin
      if (cpu_ack_o) seen = 1'b1;
      else begin @(negedge clk_i); n++; end
    end
    cpu_req_i = 1'b0;
    check("ovf_cpu_ack", 40'(seen), 40'd1);
    exp_q.push_back({1'b1, 25'h0000040, 8'h77});
    for (int i = 0; i < 4; i++) exp_q.push_back({1'b1, 25'h10 + 25'(i), 8'hC0 + 8'(i)});
    wait_log("ovf_wait", 5, 200);
    repeat (30) @(negedge clk_i);
    compare_q("ovf_wr");
    ioctl_download_i = 1'b0;

    // CAS download of 0x1234 bytes
    do_reset();
    ack_delay = 1;
    log_en    = 1'b0;
    ioctl_index_i    = 8'd2;
    ioctl_download_i = 1'b1;
    @(negedge clk_i);
    for (int i = 0; i < 24'h1234; i++) begin
      dl_byte(25'(i), 8'(i));
      repeat (4) @(negedge clk_i);
    end
    repeat (5) @(negedge clk_i);
    ioctl_download_i = 1'b0;
    @(negedge clk_i);
    check("cas_len", 40'(cas_len_o), 40'h001234);
    check("cas_valid", 40'(cas_valid_o), 40'd1);
    check("cas_err", 40'(err_o), 40'd0);
    ioctl_download_i = 1'b1;
    @(negedge clk_i);
    check("cas_restart_valid", 40'(cas_valid_o), 40'd0);
    ioctl_download_i = 1'b0;
    @(negedge clk_i);

    // Tape starvation: both requesters held continuously
    do_reset();
    ack_delay   = 1;
    cpu_we_i    = 1'b0;
    cpu_addr_i  = 25'h00000AA;
    tape_addr_i = 24'h000005;
    cpu_req_i   = 1'b1;
    tape_req_i  = 1'b1;
    wait_log("starve_wait", 10, 300);
    cpu_req_i  = 1'b0;
    tape_req_i = 1'b0;
    for (int i = 0; i < 10; i++)
      exp_q.push_back((i == 8) ? {1'b0, 25'h0100005, 8'h00} : {1'b0, 25'h00000AA, 8'h00});
    while (got_q.size() > 10) void'(got_q.pop_back());
    compare_q("starve_seq");

    // CPU read returns controller data one cycle after mem_ack_i
    do_reset();
    ack_delay  = 2;
    rd_data    = 8'hA5;
    cpu_we_i   = 1'b0;
    cpu_addr_i = 25'h0123456;
    cpu_req_i  = 1'b1;
    seen = 1'b0;
    tape_seen = 1'b0;
    n = 0;
    while (!seen && n < 50) begin
      @(negedge clk_i);
      n++;
      if (tape_ack_o) tape_seen = 1'b1;
      if (cpu_ack_o) seen = 1'b1;
    end
    cpu_req_i = 1'b0;
    check("rd_ack", 40'(seen), 40'd1);
    check("rd_data", 40'(cpu_dout_o), 40'hA5);
    check("rd_latency", 40'(n >= 3), 40'd1);
    check("rd_no_tape_ack", 40'(tape_seen), 40'd0);
    @(negedge clk_i);
    check("rd_ack_pulse", 40'(cpu_ack_o), 40'd0);
    exp_q.push_back({1'b0, 25'h0123456, 8'h00});
    compare_q("rd_addr");

    // Ack timeout
    do_reset();
    ack_en     = 1'b0;
    cpu_we_i   = 1'b1;
    cpu_addr_i = 25'h0000055;
    cpu_din_i  = 8'h99;
    cpu_req_i  = 1'b1;
    n = 0;
    while (!mem_req_o && n < 20) begin @(negedge clk_i); n++; end
    n = 0;
    seen = 1'b0;
    while (mem_req_o && n < 400) begin
      n++;
      @(negedge clk_i);
      if (cpu_ack_o) seen = 1'b1;
    end
    cpu_req_i = 1'b0;
    check("tmo_cycles", 40'(n), 40'd255);
    check("tmo_err", 40'(err_o), 40'd1);
    check("tmo_state", 40'(state_o), 40'd0);
    check("tmo_no_ack", 40'(seen), 40'd0);
    @(negedge clk_i);
    check("tmo_req_low", 40'(mem_req_o), 40'd0);
    reset_n_i = 1'b0;
    #2;
    check("tmo_err_cleared", 40'(err_o), 40'd0);
    do_reset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
